// File: rtl/seq_det_pkg.sv
// Shared "101" detector state encoding and transition function.
package seq_det_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT1  = 2'b01,
    GOT10 = 2'b10,
    MATCH = 2'b11
  } dstate_t;

  // Moore "101" detector with overlap: next context for one input bit
  function automatic dstate_t seq_next(input dstate_t s, input logic d);
    dstate_t n;
    n = IDLE;
    case (s)
      IDLE:    n = d ? GOT1  : IDLE;
      GOT1:    n = d ? GOT1  : GOT10;
      GOT10:   n = d ? MATCH : IDLE;
      MATCH:   n = d ? GOT1  : GOT10;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Request/event bus between serial receivers, the scheduler and the match consumer.
interface seq_det_scheduler_if #(
  parameter int unsigned NCH = 4
);
  import seq_det_pkg::*;

  localparam int unsigned CW = $clog2(NCH);

  logic [NCH-1:0]   req;
  logic [NCH-1:0]   din;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   gnt;
  logic             det_valid;
  logic [CW-1:0]    det_ch;
  logic             det_hit;
  logic [CW-1:0]    cnt_sel;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output req, din, clr, cnt_sel,
    input  gnt, det_valid, det_ch, det_hit, hit_cnt
  );

  modport slave (
    input  req, din, clr, cnt_sel,
    output gnt, det_valid, det_ch, det_hit, hit_cnt
  );

endinterface

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// Round-robin arbiter: first eligible requester at or above ptr, wrapping mod N.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned W = $clog2(N);

  // Scan N candidates starting from ptr, keep the first eligible one
  always_comb begin
    logic [W-1:0] c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = W'((32'(ptr) + i) % N);
      if (!any && elig[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Time-multiplexed "101" detector shared across NCH serial channels.
// Optional per-channel saturating hit counters: SEQ_DET_SCHED_HITCNT_EN.
module seq_det_scheduler #(
  parameter int unsigned NCH = 4
) (
  input logic                clk,
  input logic                rst,
  seq_det_scheduler_if.slave bus
);
  import seq_det_pkg::*;

  localparam int unsigned CW = $clog2(NCH);

  dstate_t        ctx_q [NCH];
  dstate_t        ctx_d [NCH];
  logic [CW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] gnt;
  logic [CW-1:0]  gidx;
  logic           gany;
  dstate_t        gnxt;

  logic           det_valid_q, det_valid_d;
  logic [CW-1:0]  det_ch_q, det_ch_d;
  logic           det_hit_q, det_hit_d;

  // A channel being cleared is held off this cycle; nothing is granted in reset
  assign elig = rst ? (bus.req & ~bus.clr) : '0;

  rr_arbiter #(.N(NCH)) u_arb (
    .elig (elig),
    .ptr  (ptr_q),
    .gnt  (gnt),
    .idx  (gidx),
    .any  (gany)
  );

  assign bus.gnt = gnt;

  // Shared next-state logic, applied to the granted channel only
  assign gnxt = seq_next(ctx_q[gidx], bus.din[gidx]);

  // Next context array and round-robin pointer
  always_comb begin
    ctx_d = ctx_q;
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (bus.clr[i]) begin
        ctx_d[i] = IDLE;
      end else if (gnt[i]) begin
        ctx_d[i] = gnxt;
      end
    end
    if (gany) begin
      ptr_d = (32'(gidx) == NCH - 1) ? '0 : CW'(32'(gidx) + 1);
    end
  end

  // Next event outputs; channel and hit hold when nothing was granted
  always_comb begin
    det_valid_d = gany;
    det_ch_d    = det_ch_q;
    det_hit_d   = det_hit_q;
    if (gany) begin
      det_ch_d  = gidx;
      det_hit_d = (gnxt == MATCH);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ctx_q[i] <= IDLE;
      end
      ptr_q       <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      det_hit_q   <= 1'b0;
    end else begin
      ctx_q       <= ctx_d;
      ptr_q       <= ptr_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      det_hit_q   <= det_hit_d;
    end
  end

  assign bus.det_valid = det_valid_q;
  assign bus.det_ch    = det_ch_q;
  assign bus.det_hit   = det_hit_q;

`ifdef SEQ_DET_SCHED_HITCNT_EN
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  // Saturating per-channel match counters, zeroed by the channel clear
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (bus.clr[i]) begin
        cnt_d[i] = '0;
      end else if (gnt[i] && (gnxt == MATCH) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.hit_cnt = (32'(bus.cnt_sel) < NCH) ? cnt_q[bus.cnt_sel] : '0;
`else
  logic unused_cnt_sel;

  assign unused_cnt_sel = ^bus.cnt_sel;
  assign bus.hit_cnt    = '0;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Scoreboard bench for seq_det_scheduler (NCH=4), directed vectors.
module tb_seq_det_scheduler;

  localparam int unsigned NCH = 4;
`ifdef SEQ_DET_SCHED_HITCNT_EN
  localparam bit HC = 1'b1;
`else
  localparam bit HC = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] ch;
    logic       hit;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  ev_t  expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   ev_cnt   = 0;

  always #5 clk = ~clk;

  seq_det_scheduler_if #(.NCH(NCH)) bus ();

  seq_det_scheduler #(.NCH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [1:0] oh_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One cycle: drive, check combinational grant, queue the expected event
  task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic [3:0] c,
                     input logic [3:0] eg, input logic eh, input string tag);
    ev_t e;
    bus.req = r;
    bus.din = d;
    bus.clr = c;
    #1;
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(eg));
    if (eg != 4'b0000) begin
      e.ch  = oh_idx(eg);
      e.hit = eh;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented event must match the head of the queue
  always @(negedge clk) begin
    ev_t e;
    if (rst && bus.det_valid) begin
      ev_cnt++;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL event_unexpected actual ch=%0d hit=%0d required=no event",
                 bus.det_ch, bus.det_hit);
      end else begin
        e = expq.pop_front();
        if (bus.det_ch !== e.ch || bus.det_hit !== e.hit) begin
          failures++;
          $display("FAIL event actual ch=%0d hit=%0d required ch=%0d hit=%0d",
                   bus.det_ch, bus.det_hit, e.ch, e.hit);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    logic [4:0] bits;
    logic [4:0] hits;
    logic [3:0] il_req [6];
    logic [3:0] il_din [6];
    logic [3:0] il_gnt [6];
    logic       il_hit [6];

    bits = 5'b10101;
    hits = 5'b10100;
    il_req = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0010};
    il_din = '{4'b0001, 4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0010};
    il_gnt = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
    il_hit = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0};

    bus.req = '0;
    bus.din = '0;
    bus.clr = '0;
    bus.cnt_sel = '0;
    @(posedge clk);
    #1;

    // Reset held with all channels requesting
    bus.req = 4'b1111;
    repeat (3) begin
      #1;
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_det_valid", 32'(bus.det_valid), 32'd0);
      chk("rst_det_ch", 32'(bus.det_ch), 32'd0);
      chk("rst_det_hit", 32'(bus.det_hit), 32'd0);
      chk("rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;

    // Fairness: first grant is channel 0, then strict rotation
    base = ev_cnt;
    for (int k = 0; k < 8; k++) cyc(4'b1111, 4'b0000, 4'b0000, 4'(4'b0001 << (k % 4)), 1'b0, "fair");
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle");
    chk("fair_events", 32'(ev_cnt - base), 32'd8);

    // Single channel 2: 1,0,1,0,1 -> hits on 3rd and 5th bit
    for (int k = 0; k < 5; k++) cyc(4'b0100, {1'b0, bits[k], 2'b00}, 4'b0000, 4'b0100, hits[k], "single");
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle");
    bus.cnt_sel = 2'd2;
    #1;
    chk("cnt_ch2", 32'(bus.hit_cnt), HC ? 32'd2 : 32'd0);

    // Interleave: ch0 streams 1,0,1 and ch1 streams 1,1,1
    for (int k = 0; k < 6; k++) cyc(il_req[k], il_din[k], 4'b0000, il_gnt[k], il_hit[k], "ileave");

    // ch1 should be in GOT1: 0 -> GOT10, 1 -> MATCH, 0 -> GOT10
    cyc(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, "probe");
    cyc(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, "probe");
    cyc(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, "probe");

    // Clear collision on ch1 in GOT10 with din=1, then re-present the bit
    cyc(4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b0, "clr_coll");
    cyc(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, "re_present");

    // Two simultaneous clears; only ch0 remains eligible
    cyc(4'b0111, 4'b0000, 4'b0110, 4'b0001, 1'b0, "multi_clr");
    chk("cnt_ch2_cleared", 32'(bus.hit_cnt), 32'd0);

    // Counter saturation on channel 3
    bus.cnt_sel = 2'd3;
    cyc(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, "cnt");
    for (int m = 1; m <= 300; m++) begin
      cyc(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, "cnt");
      cyc(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, "cnt");
      if (m == 1)   chk("cnt_first", 32'(bus.hit_cnt), HC ? 32'd1 : 32'd0);
      if (m == 254) chk("cnt_254", 32'(bus.hit_cnt), HC ? 32'd254 : 32'd0);
      if (m == 256) chk("cnt_sat_256", 32'(bus.hit_cnt), HC ? 32'd255 : 32'd0);
    end
    chk("cnt_sat_300", 32'(bus.hit_cnt), HC ? 32'd255 : 32'd0);
    cyc(4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b0, "clr3");
    chk("cnt_clr3", 32'(bus.hit_cnt), 32'd0);

    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "drain");
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "drain");
    chk("queue_empty", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det_scheduler.md
# seq_det_scheduler

Time-multiplexes a single "101" sequence-detection state machine across NCH serial bit channels. Each channel keeps its own 2-bit detector context. A round-robin arbiter grants one pending channel per cycle, and the shared next-state logic advances that channel's context. The block sits between the per-channel serial receivers and the match-event consumer, replacing one detector per channel.

## Interface
- NCH, 4: number of channels; 2..16.
- CW, $clog2(NCH): channel index width; derived, not overridden.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NCH  per-channel request; the channel holds din stable while req=1 and gnt=0.
- din  in  NCH  per-channel serial bit, sampled when req[i]&gnt[i].
- clr  in  NCH  per-channel synchronous context clear to IDLE.
- gnt  out  NCH  one-hot grant, combinational from req, clr and the rr pointer; 0 when nothing is eligible.
- det_valid  out  1  registered pulse: one channel's context was updated last cycle.
- det_ch  out  CW  channel index of that update.
- det_hit  out  1  the updated context entered MATCH.
- cnt_sel  in  CW  hit-counter read select (see Configuration).
- hit_cnt  out  8  hit count of channel cnt_sel (see Configuration).

## Operation
- Detector states per channel: IDLE=2'b00, GOT1=2'b01, GOT10=2'b10, MATCH=2'b11. The detector is Moore and detects overlapping patterns.
- Transitions, written as state with d=0 / state with d=1:
  - IDLE: IDLE / GOT1.
  - GOT1: GOT10 / GOT1.
  - GOT10: IDLE / MATCH.
  - MATCH: GOT10 / GOT1.
- Eligibility: channel i is eligible when req[i]=1 and clr[i]=0.
- Arbitration: round-robin over eligible channels, searching upward from pointer ptr (mod NCH).
  - After a grant to channel k, ptr becomes (k+1) mod NCH.
  - With no grant, ptr holds.
- Context update: on the edge where gnt[k]=1, ctx[k] becomes next(ctx[k], din[k]). Ungranted contexts hold.
- Clear: clr[i]=1 sets ctx[i] to IDLE on the next edge. Channel i is not granted that cycle; its bit stays pending and the requester re-presents it.
- Events: det_valid, det_ch and det_hit are registered from the granted channel and its computed next state.
  - det_hit=1 iff the next state is MATCH.
  - With no grant, det_valid=0. det_ch and det_hit then hold their previous values.
- Multiple clr bits may be asserted simultaneously. Each one is independent.

## Timing
- Reset values:
  - All ctx: IDLE.
  - ptr: 0.
  - det_valid: 0; det_ch: 0; det_hit: 0.
  - hit_cnt: 0.
  - gnt is 0 while rst=0.
- Grant latency: gnt is valid in the same cycle req rises (combinational).
- Event latency: a bit granted in cycle t produces det_valid in cycle t+1.
- Throughput: one bit per cycle in aggregate. With all NCH channels requesting continuously, each channel is served every NCH cycles.
- Reset mid-stream: all contexts return to IDLE immediately (asynchronous). Partial patterns are lost.
- Reset deassertion is synchronized externally; the block assumes a clean release.

## Configuration
- SEQ_DET_SCHED_HITCNT_EN defined:
  - Each channel has an 8-bit hit counter that increments on every det_hit for that channel and saturates at 255.
  - clr[i] zeroes counter i.
  - hit_cnt = counter[cnt_sel] (combinational read).
- SEQ_DET_SCHED_HITCNT_EN undefined:
  - No counters are built.
  - hit_cnt is tied to 8'd0 and cnt_sel is ignored.

## Structure
- Package seq_det_pkg holds:
  - The detector state typedef and the four state constants.
  - The pure function seq_next(state, d) implementing the transition list above.
- Sub-module rr_arbiter (parameter N) takes the eligible vector and ptr, and returns a one-hot grant plus the granted index.
- ptr update and the context array stay in seq_det_scheduler.

## Test plan
- Reset: hold rst=0 for 3 cycles with req=4'b1111. Required: gnt=0, det_valid=0, hit_cnt=0 throughout; after release, first grant is channel 0.
- Single channel: on channel 2 only, present bits 1,0,1,0,1. Required: det_hit=1 on the 3rd and 5th events (overlap), det_ch=2 on every event.
- Fairness: hold req=4'b1111 for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3, and det_valid high on 8 consecutive cycles.
- Interleaving: stream 1,0,1 on channel 0 and 1,1,1 on channel 1 concurrently. Required: only channel 0 reports det_hit=1; channel 1 context ends in GOT1.
- Clear collision: channel 1 is in GOT10 and asserts req and clr with din=1 in the same cycle. Required: gnt[1]=0 and ctx[1]=IDLE. When the bit is re-presented next cycle, det_hit=0.
- Counter, with SEQ_DET_SCHED_HITCNT_EN defined: drive 300 matches on channel 3 with cnt_sel=3. Required: hit_cnt=255. Then pulse clr[3]: hit_cnt=0 next cycle. With the macro undefined, the same stimulus gives hit_cnt=0.
